// File: rtl/mac_pkg.sv
// Shared constants, types and helpers for the mac_vec dot-product block.
package mac_pkg;

    localparam int DEF_A_W        = 4;
    localparam int DEF_B_W        = 4;
    localparam int DEF_VEC_LEN    = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mac_state_e;

    // Accumulator width large enough that a full vector of extreme products cannot overflow.
    function automatic int acc_width(input int a_w, input int b_w, input int len);
        return a_w + b_w + $clog2(len);
    endfunction

endpackage

// File: rtl/mac_fifo.sv
// Operand FIFO for mac_vec: power-of-two depth, synchronous flush,
// asynchronous active-low reset. Ready depends only on registered pointers,
// so a full FIFO refuses a push even in a cycle where it is popped.
module mac_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign push_ready = !full;
    assign do_push    = push_valid && !full && !flush;
    assign do_pop     = pop && !empty && !flush;
    assign pop_data   = mem[rd_ptr[PTR_W-1:0]];

    // Storage array needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    // Pointer update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_vec.sv
// Signed vector multiply-accumulate. Operands A and B are buffered in their
// own FIFOs, paired in arrival order, multiplied into stage P and summed
// VEC_LEN at a time; each sum is presented on mac_out with a one-cycle
// out_valid strobe.
// Build option: define MAC_SAT_EN to saturate (rather than wrap) the result
// when OUT_W is narrower than the accumulator.
module mac_vec
    import mac_pkg::*;
#(
    parameter int A_W        = DEF_A_W,
    parameter int B_W        = DEF_B_W,
    parameter int VEC_LEN    = DEF_VEC_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int OUT_W      = acc_width(A_W, B_W, VEC_LEN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [A_W-1:0]          in_a,
    input  logic                    in_valid_a,
    output logic                    in_ready_a,
    input  logic [B_W-1:0]          in_b,
    input  logic                    in_valid_b,
    output logic                    in_ready_b,
    input  logic                    in_clear,
    output logic signed [OUT_W-1:0] mac_out,
    output logic                    out_valid
);

    localparam int PROD_W = A_W + B_W;
    localparam int ACC_W  = acc_width(A_W, B_W, VEC_LEN);
    localparam int CNT_W  = $clog2(VEC_LEN);

    logic [A_W-1:0]           a_data;
    logic [B_W-1:0]           b_data;
    logic                     a_empty;
    logic                     b_empty;
    logic                     pair_pop;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod_next;
    logic signed [PROD_W-1:0] prod;
    logic                     prod_vld;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]         cnt;
    logic                     last;
    logic signed [OUT_W-1:0]  fit_val;
    mac_state_e               state;

    mac_fifo #(
        .WIDTH (A_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk        (clk),
        .reset      (reset),
        .flush      (in_clear),
        .push_valid (in_valid_a),
        .push_data  (in_a),
        .push_ready (in_ready_a),
        .pop        (pair_pop),
        .pop_data   (a_data),
        .empty      (a_empty)
    );

    mac_fifo #(
        .WIDTH (B_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk        (clk),
        .reset      (reset),
        .flush      (in_clear),
        .push_valid (in_valid_b),
        .push_data  (in_b),
        .push_ready (in_ready_b),
        .pop        (pair_pop),
        .pop_data   (b_data),
        .empty      (b_empty)
    );

    // A pair is consumed whenever both streams have an operand waiting.
    assign pair_pop  = !a_empty && !b_empty;

    // Operands are sign-extended to the full product width so the multiply is exact.
    assign a_ext     = {{B_W{a_data[A_W-1]}}, a_data};
    assign b_ext     = {{A_W{b_data[B_W-1]}}, b_data};
    assign prod_next = a_ext * b_ext;

    assign prod_ext  = {{CNT_W{prod[PROD_W-1]}}, prod};
    assign acc_sum   = acc + prod_ext;
    assign last      = (cnt == CNT_W'(VEC_LEN - 1));

    // Width fit of the full-precision sum onto mac_out.
    generate
        if (OUT_W == ACC_W) begin : g_fit_same
            assign fit_val = acc_sum;
        end else if (OUT_W > ACC_W) begin : g_fit_wide
            assign fit_val = {{(OUT_W - ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
        end else begin : g_fit_narrow
`ifdef MAC_SAT_EN
            localparam logic signed [ACC_W-1:0] SAT_MAX =
                {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
            localparam logic signed [ACC_W-1:0] SAT_MIN =
                {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

            // Clamp the sum into the signed range representable on mac_out.
            always_comb begin
                fit_val = acc_sum[OUT_W-1:0];
                if (acc_sum > SAT_MAX) begin
                    fit_val = SAT_MAX[OUT_W-1:0];
                end else if (acc_sum < SAT_MIN) begin
                    fit_val = SAT_MIN[OUT_W-1:0];
                end
            end
`else
            assign fit_val = acc_sum[OUT_W-1:0];
`endif
        end
    endgenerate

    // Stage P: register the product of each popped pair; clear discards it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod     <= '0;
            prod_vld <= 1'b0;
        end else if (in_clear) begin
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= pair_pop;
            if (pair_pop) begin
                prod <= prod_next;
            end
        end
    end

    // Accumulate products; the last one of a vector emits the result and restarts at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            cnt       <= '0;
            mac_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (prod_vld) begin
                if (last) begin
                    mac_out   <= fit_val;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Activity tracker: RUN from the first pair pop until a vector completes with nothing pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (in_clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pair_pop) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (prod_vld && last && !pair_pop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mac_vec.md
# mac_vec

Parametrised signed multiply-accumulate unit for the datapath's dot-product stage. Operand streams A and B arrive on independent valid/ready handshakes. Each stream is buffered in its own FIFO, and operands are paired strictly in arrival order. Every VEC_LEN products are summed and presented on `mac_out` with a one-cycle `out_valid` strobe.

## Interface
- `A_W`, 4: signed width of operand A.
- `B_W`, 4: signed width of operand B.
- `VEC_LEN`, 8: products per result; must be at least 2.
- `FIFO_DEPTH`, 4: entries per operand FIFO; power of two, at least 2.
- `OUT_W`, `A_W+B_W+$clog2(VEC_LEN)`: width of `mac_out`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_a`, input, A_W: signed operand A.
- `in_valid_a`, input, 1: A valid.
- `in_ready_a`, output, 1: A FIFO not full.
- `in_b`, input, B_W: signed operand B.
- `in_valid_b`, input, 1: B valid.
- `in_ready_b`, output, 1: B FIFO not full.
- `in_clear`, input, 1: synchronous flush.
- `mac_out`, output, OUT_W: signed result.
- `out_valid`, output, 1: one-cycle result strobe.

## Operation
- **Accept:** an operand is accepted when valid and ready are both high at a rising edge. Ready is `!full` and is registered-state only, with no combinational path from the pop. A full FIFO therefore refuses input even in a cycle where it pops.
- **Pair:** when both FIFOs are non-empty, one entry is popped from each. Their product is registered in stage P (`prod`, A_W+B_W bits, signed) with `prod_vld`.
- **Accumulate:**
  - Accumulator `acc` is ACC_W = A_W+B_W+$clog2(VEC_LEN) bits and cannot overflow.
  - Counter `cnt` runs 0..VEC_LEN-1.
  - On `prod_vld` with cnt < VEC_LEN-1: `acc += prod`, `cnt++`.
  - On `prod_vld` with cnt == VEC_LEN-1: `mac_out <= fit(acc+prod)`, `out_valid <= 1`, `acc <= 0`, `cnt <= 0`.
- **Back-to-back vectors:** no bubble; the next vector's first product may arrive in the cycle after the final one.
- **FSM:**
  - IDLE: cnt == 0 and `!prod_vld`. Moves to RUN on the first pair pop.
  - RUN: returns to IDLE after the final accumulate if no further pair is pending.
- **Width fit:** `fit()` is identity when OUT_W >= ACC_W, sign-extending if wider. Narrower OUT_W is handled per Configuration.
- **Clear:** `in_clear` empties both FIFOs, drops `prod_vld`, and zeroes `acc` and `cnt`.
  - Clear wins over any simultaneous push, pop or final accumulate; no `out_valid` is produced for the dropped vector.
  - `mac_out` holds its last value.
- **Reset** (asynchronous, any time, including mid-vector):
  - `mac_out` = 0, `out_valid` = 0.
  - `in_ready_a` = `in_ready_b` = 1.
  - FIFOs empty, `acc` = 0, `cnt` = 0, FSM in IDLE.

## Timing
- **Latency:** with both FIFOs empty, the last operand pair accepted at edge E0 is popped at E1, and `out_valid` is high for the cycle after E2. That is 2 edges of latency.
- **Skew:** operands may arrive with arbitrary relative skew. The leading stream stalls only when its FIFO holds FIFO_DEPTH unpaired entries.
- **Throughput:** 1 product per cycle, and 1 result per VEC_LEN cycles, when both streams are continuous.
- **Output hold:** `out_valid` never stays high for two consecutive cycles. `mac_out` holds until the next result.

## Configuration
- `MAC_SAT_EN` defined, and OUT_W < ACC_W: the full-precision sum is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- `MAC_SAT_EN` not defined: the low OUT_W bits are kept (two's-complement wrap).
- With OUT_W >= ACC_W, the macro has no effect.

## Structure
- **Package `mac_pkg`:**
  - Default width constants.
  - `acc_width(a_w, b_w, len)` function.
  - FSM state enum `{IDLE, RUN}`.
- **Sub-module `mac_fifo`:** parametrised width and depth, synchronous flush, asynchronous active-low reset. It is instantiated once for A and once for B.

## Test plan
- **Basic sum:** a=3, b=2 paired for 8 consecutive cycles → `mac_out` = 48, one `out_valid` pulse 2 edges after the last accept.
- **Extremes:** a=-8, b=-8 ×8 → 512; then immediately a=-8, b=7 ×8 → -448, back-to-back, two pulses 8 cycles apart.
- **Skew:** A driven for 5 cycles with B idle → `in_ready_a` low on the 5th cycle. B then streams → pairs match in order, and the result equals the reference dot product.
- **Narrow output:** OUT_W=9, a=-8, b=-8 ×8 → 255 with `MAC_SAT_EN`, 0 without.
- **Clear on final product:** `in_clear` asserted in the cycle of the final product → no `out_valid`. The following full vector a=1, b=1 ×8 → 8.
- **Reset mid-vector:** `reset` low after 4 products → outputs are 0 and readies are 1 immediately. The next full vector a=2, b=-3 ×8 → -48.
